inst_fetch_buffer: RTL and testbench

//  Downstream of the bus fetch stage. Takes the 64-bit instruction beats streamed off the system bus
//  and splits each beat into two 32-bit instructions, each tagged with its PC.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/inst_fetch_buffer_if.sv | 36 +++
 rtl/inst_fetch_buffer_dual_push_fifo.sv | 64 ++++++
 rtl/inst_fetch_buffer.sv | 145 ++++++++++++++
 tb/tb_inst_fetch_buffer.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module : fetch_pkg
// Brief  : Shared widths and entry type for the instruction fetch buffer.
// Rev    : 1.0
// ============================================================================
package fetch_pkg;

  localparam int INST_W = 32;
  localparam int BEAT_W = 64;
  localparam int PC_W   = 64;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } inst_entry_t;

  function automatic logic [PC_W-1:0] line_base(input logic [PC_W-1:0] pc);
    return pc & ~64'h7;
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_fetch_buffer_if.sv
`default_nettype none
// ============================================================================
// Module : inst_fetch_buffer_if
// Brief  : Beat input, instruction output and status bundle of the fetch buffer.
// Rev    : 1.0
// ============================================================================
interface inst_fetch_buffer_if #(
  parameter int DEPTH = 16
);

  logic                          start_valid;
  logic [fetch_pkg::PC_W-1:0]    start_pc;
  logic                          beat_valid;
  logic [fetch_pkg::BEAT_W-1:0]  beat_data;
  logic                          flush;
  logic                          line_ready;
  logic                          inst_valid;
  logic [fetch_pkg::INST_W-1:0]  inst;
  logic [fetch_pkg::PC_W-1:0]    inst_pc;
  logic                          inst_ready;
  logic                          halt;
  logic                          overflow;
  logic [$clog2(DEPTH):0]        occupancy;

  modport master (
    output start_valid, start_pc, beat_valid, beat_data, flush, inst_ready,
    input  line_ready, inst_valid, inst, inst_pc, halt, overflow, occupancy
  );

  modport slave (
    input  start_valid, start_pc, beat_valid, beat_data, flush, inst_ready,
    output line_ready, inst_valid, inst, inst_pc, halt, overflow, occupancy
  );

endinterface
`default_nettype wire

// File: rtl/inst_fetch_buffer_dual_push_fifo.sv
`default_nettype none
// ============================================================================
// Module : dual_push_fifo
// Brief  : FIFO of inst_entry_t taking up to two writes and one read per cycle.
// Rev    : 1.0
// ============================================================================
module dual_push_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  wire logic                   clk,
  input  wire logic                   reset,
  input  wire logic                   flush,
  input  wire logic [1:0]             push_cnt,
  input  wire inst_entry_t            push_data0,
  input  wire inst_entry_t            push_data1,
  input  wire logic                   pop,
  output inst_entry_t                 head,
  output logic [$clog2(DEPTH):0]      count,
  output logic [$clog2(DEPTH):0]      free
);

  localparam int c_aw = $clog2(DEPTH);

  inst_entry_t       r_mem [DEPTH];
  logic [c_aw:0]     r_wr_ptr;
  logic [c_aw:0]     r_rd_ptr;
  logic [c_aw-1:0]   w_wr_idx0;
  logic [c_aw-1:0]   w_wr_idx1;

  assign w_wr_idx0 = r_wr_ptr[c_aw-1:0];
  assign w_wr_idx1 = r_wr_ptr[c_aw-1:0] + c_aw'(1);

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + (c_aw+1)'(push_cnt);
      if (pop && (count != '0)) begin
        r_rd_ptr <= r_rd_ptr + (c_aw+1)'(1);
      end
    end
  end

  // Storage carries no reset; the head is masked to zero whenever empty.
  always_ff @(posedge clk) begin
    if (reset && !flush) begin
      if (push_cnt != 2'd0) begin
        r_mem[w_wr_idx0] <= push_data0;
      end
      if (push_cnt == 2'd2) begin
        r_mem[w_wr_idx1] <= push_data1;
      end
    end
  end

  assign count = r_wr_ptr - r_rd_ptr;
  assign free  = (c_aw+1)'(DEPTH) - count;
  assign head  = (count != '0) ? r_mem[r_rd_ptr[c_aw-1:0]] : '0;

endmodule
`default_nettype wire

// File: rtl/inst_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module : inst_fetch_buffer
// Brief  : Splits 64-bit bus beats into PC-tagged instructions for decode.
// Rev    : 1.0
// ============================================================================
module inst_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int BEATS_PER_LINE = 8
) (
  input  wire logic         clk,
  input  wire logic         reset,
  inst_fetch_buffer_if.slave bus
);

  localparam int c_aw          = $clog2(DEPTH);
  localparam int c_line_thresh = (2*BEATS_PER_LINE < DEPTH) ? 2*BEATS_PER_LINE : DEPTH;

  logic [PC_W-1:0]   r_wr_pc;
  logic              r_skip_lo;
  logic              r_halt_pend;
  logic              r_halt;
  logic              r_overflow;

  inst_entry_t       w_head;
  inst_entry_t       w_d0;
  inst_entry_t       w_d1;
  logic [c_aw:0]     w_count;
  logic [c_aw:0]     w_free;
  logic [c_aw:0]     w_occ_nxt;
  logic [1:0]        w_words;
  logic [1:0]        w_push_cnt;
  logic [PC_W-1:0]   w_pc_eff;
  logic [PC_W-1:0]   w_base;
  logic              w_skip_eff;
  logic              w_term;
  logic              w_accept;
  logic              w_fits;
  logic              w_drop;
  logic              w_pop;
  logic              w_inst_valid;
  logic              w_halt_pend_nxt;
  logic [INST_W-1:0] w_lo;
  logic [INST_W-1:0] w_hi;

  assign w_lo = bus.beat_data[31:0];
  assign w_hi = bus.beat_data[63:32];

  always_comb begin
    w_pc_eff   = bus.start_valid ? bus.start_pc : r_wr_pc;
    w_skip_eff = bus.start_valid ? bus.start_pc[2] : r_skip_lo;
    w_base     = line_base(w_pc_eff);
    w_words    = 2'd0;
    w_term     = 1'b0;
    w_d0       = '0;
    w_d1       = '0;
    // A zero word terminates the stream and suppresses everything after it.
    if (!w_skip_eff) begin
      if (w_lo == '0) begin
        w_term = 1'b1;
      end else begin
        w_d0    = '{pc: w_base, inst: w_lo};
        w_words = 2'd1;
        if (w_hi == '0) begin
          w_term = 1'b1;
        end else begin
          w_d1    = '{pc: w_base + 64'd4, inst: w_hi};
          w_words = 2'd2;
        end
      end
    end else begin
      if (w_hi == '0) begin
        w_term = 1'b1;
      end else begin
        w_d0    = '{pc: w_base + 64'd4, inst: w_hi};
        w_words = 2'd1;
      end
    end
  end

  assign w_inst_valid    = (w_count != '0);
  assign w_accept        = bus.beat_valid && !bus.flush && !r_halt_pend;
  assign w_fits          = ((c_aw+1)'(w_words) <= w_free);
  assign w_push_cnt      = (w_accept && w_fits) ? w_words : 2'd0;
  assign w_drop          = w_accept && !w_fits;
  assign w_pop           = w_inst_valid && bus.inst_ready && !bus.flush;
  assign w_halt_pend_nxt = !bus.flush && (r_halt_pend || (w_accept && w_fits && w_term));
  assign w_occ_nxt       = bus.flush ? '0
                         : w_count + (c_aw+1)'(w_push_cnt) - (c_aw+1)'(w_pop);

  dual_push_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (bus.flush),
    .push_cnt   (w_push_cnt),
    .push_data0 (w_d0),
    .push_data1 (w_d1),
    .pop        (w_pop),
    .head       (w_head),
    .count      (w_count),
    .free       (w_free)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_pc     <= '0;
      r_skip_lo   <= 1'b0;
      r_halt_pend <= 1'b0;
      r_halt      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (bus.start_valid) begin
        r_wr_pc   <= bus.start_pc;
        r_skip_lo <= bus.start_pc[2];
      end
      // Dropped beats still advance the PC so later beats keep their addresses.
      if (w_accept) begin
        r_wr_pc   <= w_base + 64'd8;
        r_skip_lo <= 1'b0;
      end
      if (bus.flush) begin
        r_skip_lo <= 1'b0;
      end
      r_halt_pend <= w_halt_pend_nxt;
      r_halt      <= w_halt_pend_nxt && (w_occ_nxt == '0);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.inst_valid = w_inst_valid;
  assign bus.inst       = w_head.inst;
  assign bus.inst_pc    = w_head.pc;
  assign bus.occupancy  = w_count;
  assign bus.line_ready = (w_free >= (c_aw+1)'(c_line_thresh));
  assign bus.halt       = r_halt;
  assign bus.overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module : tb_inst_fetch_buffer
// Brief  : Directed and random stimulus against a queue-based reference model.
// Rev    : 1.0
// ============================================================================
module tb_inst_fetch_buffer;
  import fetch_pkg::*;

  localparam int DEPTH          = 16;
  localparam int BEATS_PER_LINE = 8;
  localparam int LINE_THRESH    = (2*BEATS_PER_LINE < DEPTH) ? 2*BEATS_PER_LINE : DEPTH;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  inst_fetch_buffer_if #(.DEPTH(DEPTH)) bus ();

  inst_fetch_buffer #(
    .DEPTH          (DEPTH),
    .BEATS_PER_LINE (BEATS_PER_LINE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  inst_entry_t m_q[$];
  logic [63:0] m_wr_pc;
  logic        m_skip;
  logic        m_hp;
  logic        m_halt;
  logic        m_ovf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    inst_entry_t pend[$];
    inst_entry_t e;
    logic [31:0] w [2];
    logic [63:0] pc_eff;
    logic [63:0] base;
    logic        skip_eff;
    logic        term;
    logic        pop;
    int          free;
    if (!reset) begin
      m_q.delete();
      m_wr_pc = '0; m_skip = 0; m_hp = 0; m_halt = 0; m_ovf = 0;
      return;
    end
    free     = DEPTH - m_q.size();
    pop      = (m_q.size() > 0) && bus.inst_ready && !bus.flush;
    pc_eff   = bus.start_valid ? bus.start_pc : m_wr_pc;
    skip_eff = bus.start_valid ? bus.start_pc[2] : m_skip;
    base     = pc_eff - (pc_eff % 64'd8);
    w[0]     = bus.beat_data[31:0];
    w[1]     = bus.beat_data[63:32];
    term     = 0;
    for (int k = (skip_eff ? 1 : 0); k < 2; k++) begin
      if (w[k] == 32'd0) begin
        term = 1;
        break;
      end
      e.pc   = base + 64'(4 * k);
      e.inst = w[k];
      pend.push_back(e);
    end
    if (bus.flush) begin
      m_q.delete();
      m_hp   = 0;
      m_skip = 0;
      if (bus.start_valid) m_wr_pc = bus.start_pc;
    end else begin
      if (bus.start_valid) begin
        m_wr_pc = bus.start_pc;
        m_skip  = bus.start_pc[2];
      end
      if (pop) void'(m_q.pop_front());
      if (bus.beat_valid && !m_hp) begin
        if (pend.size() <= free) begin
          foreach (pend[i]) m_q.push_back(pend[i]);
          if (term) m_hp = 1;
        end else begin
          m_ovf = 1;
        end
        m_wr_pc = base + 64'd8;
        m_skip  = 0;
      end
    end
    m_halt = m_hp && (m_q.size() == 0);
  endtask

  task automatic check_outputs(input string tag);
    logic exp_v;
    exp_v = (m_q.size() > 0);
    check({tag, ".valid"}, 64'(bus.inst_valid), 64'(exp_v));
    check({tag, ".inst"},  64'(bus.inst), exp_v ? 64'(m_q[0].inst) : 64'd0);
    check({tag, ".pc"},    bus.inst_pc, exp_v ? m_q[0].pc : 64'd0);
    check({tag, ".occ"},   64'(bus.occupancy), 64'(m_q.size()));
    check({tag, ".lr"},    64'(bus.line_ready), 64'((DEPTH - m_q.size()) >= LINE_THRESH));
    check({tag, ".halt"},  64'(bus.halt), 64'(m_halt));
    check({tag, ".ovf"},   64'(bus.overflow), 64'(m_ovf));
  endtask

  task automatic drive(input logic sv, input logic [63:0] spc, input logic bv,
                       input logic [63:0] bd, input logic fl, input logic rdy);
    bus.start_valid = sv;
    bus.start_pc    = spc;
    bus.beat_valid  = bv;
    bus.beat_data   = bd;
    bus.flush       = fl;
    bus.inst_ready  = rdy;
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_outputs(tag);
  endtask

  function automatic logic [31:0] rand_word(input int zero_odds);
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, zero_odds) == 0) r = 32'd0;
    else if (r == 32'd0) r = 32'd1;
    return r;
  endfunction

  initial begin
    int rdy_pct;
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    drive(0, '0, 0, '0, 0, 0);
    cycle("rst0");
    cycle("rst1");
    check("rst_lr", 64'(bus.line_ready), 64'd1);
    check("rst_valid", 64'(bus.inst_valid), 64'd0);
    reset = 1'b1;

    // Two beats split into four instructions in address order
    drive(1, 64'h1000, 1, 64'h00000013_00100093, 0, 1);
    cycle("t1a");
    check("t1_inst0", 64'(bus.inst), 64'h00100093);
    check("t1_pc0", bus.inst_pc, 64'h1000);
    drive(0, '0, 1, 64'h00200113_00300193, 0, 1);
    cycle("t1b");
    check("t1_inst1", 64'(bus.inst), 64'h00000013);
    check("t1_pc1", bus.inst_pc, 64'h1004);
    drive(0, '0, 0, '0, 0, 1);
    cycle("t1c");
    check("t1_inst2", 64'(bus.inst), 64'h00300193);
    check("t1_pc2", bus.inst_pc, 64'h1008);
    cycle("t1d");
    check("t1_inst3", 64'(bus.inst), 64'h00200113);
    check("t1_pc3", bus.inst_pc, 64'h100C);
    cycle("t1e");

    // Misaligned start skips the lower word
    drive(1, 64'h2004, 1, 64'hAAAA0001_BBBB0002, 0, 0);
    cycle("t2a");
    check("t2_occ", 64'(bus.occupancy), 64'd1);
    check("t2_inst", 64'(bus.inst), 64'hAAAA0001);
    check("t2_pc", bus.inst_pc, 64'h2004);
    drive(0, '0, 0, '0, 0, 1);
    cycle("t2b");

    // Terminator in upper word, later beat ignored, halt after drain
    drive(0, '0, 1, 64'h00000000_00500293, 0, 0);
    cycle("t3a");
    check("t3_inst", 64'(bus.inst), 64'h00500293);
    check("t3_pc", bus.inst_pc, 64'h2008);
    drive(0, '0, 1, 64'h11111111_22222222, 0, 1);
    cycle("t3b");
    check("t3_occ", 64'(bus.occupancy), 64'd0);
    check("t3_halt", 64'(bus.halt), 64'd1);
    drive(0, '0, 1, 64'h33333333_44444444, 0, 1);
    cycle("t3c");
    check("t3_ignored", 64'(bus.occupancy), 64'd0);
    drive(0, '0, 0, '0, 1, 0);
    cycle("t3d");
    check("t3_unhalt", 64'(bus.halt), 64'd0);

    // Fill to capacity, ninth beat dropped
    for (int b = 0; b < 9; b++) begin
      drive(b == 0, 64'h3000, 1, {rand_word(1000000) | 32'h1, rand_word(1000000) | 32'h1}, 0, 0);
      cycle("t4");
    end
    check("t4_occ", 64'(bus.occupancy), 64'd16);
    check("t4_ovf", 64'(bus.overflow), 64'd1);
    check("t4_lr", 64'(bus.line_ready), 64'd0);
    drive(0, '0, 1, 64'h5, 0, 1);
    cycle("t4_fullpop");

    // Flush with a same-cycle beat and pop
    drive(0, '0, 0, '0, 1, 0);
    cycle("t5f");
    drive(1, 64'h4004, 1, 64'h12345678_00000001, 0, 0);
    cycle("t5a");
    drive(0, '0, 1, 64'h22222222_11111111, 0, 0);
    cycle("t5b");
    cycle("t5c");
    check("t5_occ5", 64'(bus.occupancy), 64'd5);
    drive(0, '0, 1, 64'h44444444_33333333, 1, 1);
    cycle("t5d");
    check("t5_occ0", 64'(bus.occupancy), 64'd0);
    check("t5_valid", 64'(bus.inst_valid), 64'd0);
    drive(0, '0, 0, '0, 0, 0);
    cycle("t5e");

    // Reset mid-stream
    drive(1, 64'h5000, 1, 64'h66666666_55555555, 0, 0);
    cycle("t6a");
    drive(0, '0, 1, 64'h88888888_77777777, 0, 0);
    reset = 1'b0;
    cycle("t6r");
    check("t6_valid", 64'(bus.inst_valid), 64'd0);
    check("t6_ovf", 64'(bus.overflow), 64'd0);
    check("t6_occ", 64'(bus.occupancy), 64'd0);
    check("t6_lr", 64'(bus.line_ready), 64'd1);
    reset = 1'b1;

    // Randomized traffic
    rdy_pct = 60;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        case ($urandom_range(0, 2))
          0: rdy_pct = 20;
          1: rdy_pct = 60;
          default: rdy_pct = 95;
        endcase
      end
      reset = ($urandom_range(0, 299) != 0);
      drive($urandom_range(0, 99) < 3,
            {$urandom, $urandom} & ~64'h3,
            $urandom_range(0, 99) < 70,
            {rand_word(40), rand_word(40)},
            $urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < rdy_pct);
      cycle("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
